// File: rtl/led_fade.sv
// Multi-channel LED fader: per-channel saturating up/down brightness counters driving an 8-bit PWM.
// Define LED_FADE_GAMMA_EN to square the level before the PWM compare (perceptual gamma).
module led_fade #(
  parameter int unsigned NLED     = 12,
  parameter int unsigned PRESCALE = 62500,
  parameter int unsigned STEP     = 1
) (
  input  logic            clkin,
  input  logic            resetn,
  input  logic            enable,
  input  logic [NLED-1:0] led_in,
  output logic [NLED-1:0] led_out,
  output logic            busy
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(PRESCALE - 1);
  localparam logic [8:0] Step9 = 9'(STEP);

  logic [7:0]      r_pwm_cnt;
  logic [PW-1:0]   r_presc;
  logic [7:0]      r_level [NLED];
  logic [8:0]      w_up    [NLED];
  logic [8:0]      w_dn    [NLED];
  logic [7:0]      w_next  [NLED];
  logic [7:0]      w_eff   [NLED];
`ifdef LED_FADE_GAMMA_EN
  logic [15:0]     w_sq    [NLED];
`endif
  logic [NLED-1:0] w_led_d;
  logic [NLED-1:0] w_diff;
  logic            w_tick;

  assign w_tick = enable && (r_presc == PrescMax);

  always_comb begin
    for (int i = 0; i < NLED; i++) begin
      // 9-bit sums: bit 8 flags overflow above 255 or borrow below 0
      w_up[i]   = {1'b0, r_level[i]} + Step9;
      w_dn[i]   = {1'b0, r_level[i]} - Step9;
      if (led_in[i]) w_next[i] = w_up[i][8] ? 8'hFF : w_up[i][7:0];
      else           w_next[i] = w_dn[i][8] ? 8'h00 : w_dn[i][7:0];
      w_diff[i] = r_level[i] != (led_in[i] ? 8'hFF : 8'h00);
`ifdef LED_FADE_GAMMA_EN
      w_sq[i]   = 16'(r_level[i]) * 16'(r_level[i]);
      w_eff[i]  = (r_level[i] == 8'hFF) ? 8'hFF : w_sq[i][15:8];
`else
      w_eff[i]  = r_level[i];
`endif
      w_led_d[i] = enable && ((w_eff[i] == 8'hFF) || (r_pwm_cnt < w_eff[i]));
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_pwm_cnt <= 8'h00;
      r_presc   <= '0;
      for (int i = 0; i < NLED; i++) r_level[i] <= 8'h00;
      led_out   <= '0;
      busy      <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'h01;
      if (enable) r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        for (int i = 0; i < NLED; i++) r_level[i] <= w_next[i];
      end
      led_out <= w_led_d;
      busy    <= |w_diff;
    end
  end

endmodule

// File: tb/tb_led_fade.sv
// Directed self-checking bench for led_fade: reset, ramp, saturation, reversal, enable freeze, duty.
module tb_led_fade;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [11:0] led_in;
  logic [11:0] lo_a, lo_b, lo_c;
  logic        bz_a, bz_b, bz_c;
  int          checks = 0;
  int          errors = 0;
  int          cnt;

  always #5 clk = ~clk;

  led_fade #(.NLED(12), .PRESCALE(4), .STEP(64)) dut (
    .clkin(clk), .resetn(resetn), .enable(enable), .led_in(led_in), .led_out(lo_a), .busy(bz_a)
  );
  led_fade #(.NLED(12), .PRESCALE(4), .STEP(100)) dut100 (
    .clkin(clk), .resetn(resetn), .enable(enable), .led_in(led_in), .led_out(lo_b), .busy(bz_b)
  );
  led_fade #(.NLED(12), .PRESCALE(600), .STEP(64)) dutd (
    .clkin(clk), .resetn(resetn), .enable(enable), .led_in(led_in), .led_out(lo_c), .busy(bz_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b1;
    enable = 1'b1;
    led_in = 12'hFFF;
    #2 resetn = 1'b0;
    cyc(2);
    chk("rst_led_out", 32'(lo_a), 32'h0);
    chk("rst_busy", 32'(bz_a), 32'h0);
    chk("rst_level", 32'(dut.r_level[0]), 32'h0);
    chk("rst_pwm", 32'(dut.r_pwm_cnt), 32'h0);

    // Ramp up with all channels targeting 255
    resetn = 1'b1;
    cyc(1);
    chk("rel_busy", 32'(bz_a), 32'h1);
    chk("rel_led_out", 32'(lo_a), 32'h0);
    cyc(3);
    chk("c4_level", 32'(dut.r_level[0]), 32'd64);
    chk("c4_led_out", 32'(lo_a), 32'h0);
    cyc(4);
    chk("c8_level", 32'(dut.r_level[0]), 32'd128);
    chk("s100_c8_level", 32'(dut100.r_level[0]), 32'd200);
    cyc(4);
    chk("c12_level", 32'(dut.r_level[0]), 32'd192);
    chk("s100_sat_255", 32'(dut100.r_level[0]), 32'd255);
    cyc(4);
    chk("c16_level", 32'(dut.r_level[0]), 32'd255);
    chk("c16_busy", 32'(bz_a), 32'h1);
    cyc(1);
    chk("c17_busy", 32'(bz_a), 32'h0);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (lo_a !== 12'hFFF) cnt++;
      cyc(1);
    end
    chk("full_const_1", 32'(cnt), 32'd0);

    // Reversal at level 192; STEP=100 instance falls 255->155->55->0
    resetn = 1'b0;
    led_in = 12'h001;
    cyc(2);
    resetn = 1'b1;
    cyc(12);
    chk("rev_c12", 32'(dut.r_level[0]), 32'd192);
    led_in = 12'h000;
    cyc(4);
    chk("rev_c16", 32'(dut.r_level[0]), 32'd128);
    chk("s100_c16", 32'(dut100.r_level[0]), 32'd155);
    cyc(4);
    chk("rev_c20", 32'(dut.r_level[0]), 32'd64);
    chk("s100_c20", 32'(dut100.r_level[0]), 32'd55);
    cyc(4);
    chk("rev_c24", 32'(dut.r_level[0]), 32'd0);
    chk("s100_nowrap", 32'(dut100.r_level[0]), 32'd0);
    chk("rev_c24_busy", 32'(bz_a), 32'h1);
    cyc(1);
    chk("rev_c25_busy", 32'(bz_a), 32'h0);
    chk("s100_c25_busy", 32'(bz_b), 32'h0);

    // Enable low at level 128 freezes level and blanks outputs
    resetn = 1'b0;
    led_in = 12'h001;
    cyc(2);
    resetn = 1'b1;
    cyc(8);
    chk("en_c8_level", 32'(dut.r_level[0]), 32'd128);
    enable = 1'b0;
    cyc(1);
    chk("en_off_led", 32'(lo_a), 32'h0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (lo_a !== 12'h000) cnt++;
      cyc(1);
    end
    chk("en_off_hold_led", 32'(cnt), 32'd0);
    chk("en_frozen_level", 32'(dut.r_level[0]), 32'd128);
    chk("en_off_busy", 32'(bz_a), 32'h1);
    enable = 1'b1;
    cyc(3);
    chk("en_resume_wait", 32'(dut.r_level[0]), 32'd128);
    cyc(1);
    chk("en_resume_tick", 32'(dut.r_level[0]), 32'd192);
    resetn = 1'b0;
    #1;
    chk("mid_rst_level", 32'(dut.r_level[0]), 32'd0);
    chk("mid_rst_led", 32'(lo_a), 32'h0);
    chk("mid_rst_busy", 32'(bz_a), 32'h0);
    cyc(1);
    resetn = 1'b1;

    // Duty at level 64 on the slow-prescale instance
    cyc(600);
    chk("duty_level", 32'(dutd.r_level[0]), 32'd64);
    cyc(1);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      if (lo_c[0] === 1'b1) cnt++;
    end
`ifdef LED_FADE_GAMMA_EN
    chk("duty_count", 32'(cnt), 32'd16);
`else
    chk("duty_count", 32'(cnt), 32'd64);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fade.md
LED_FADE -- requirements
Module: led_fade

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NLED, default 12, giving the number of LED channels.
REQ-002 The block SHALL have parameter PRESCALE, default 62500, giving clkin cycles per fade tick (legal range 2..2^20).
REQ-003 The block SHALL have parameter STEP, default 1, giving the brightness increment per fade tick (legal range 1..255).

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clkin, input, 1, the single fabric clock (CCC fabric output); all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1, the reset: asynchronous assert, active-low.
REQ-006 The block SHALL have port enable, input, 1, which runs fading when high and forces outputs off when low.
REQ-007 The block SHALL have port led_in, input, NLED, carrying the on/off target pattern from the blinky counter.
REQ-008 The block SHALL have port led_out, output, NLED, carrying the PWM-dimmed drive to the LEDS pins.
REQ-009 The block SHALL have port busy, output, 1, which is high while any channel level differs from its target.

Function
REQ-010 The block SHALL keep an 8-bit pwm_cnt that increments every cycle and wraps 255->0, independent of enable.
REQ-011 The block SHALL keep a prescaler that counts 0..PRESCALE-1 while enable=1 and holds its value while enable=0.
REQ-012 The block SHALL assert tick for exactly one cycle when the prescaler equals PRESCALE-1, and SHALL then wrap the prescaler to 0.
REQ-013 The block SHALL keep an 8-bit level[i] per channel, with target[i] = 255 if led_in[i]=1 and 0 otherwise, sampled on the tick cycle.
REQ-014 On tick, each level SHALL step toward its target by STEP, saturating: the rising result SHALL be min(level+STEP, 255) and the falling result SHALL be max(level-STEP, 0), computed with 9-bit intermediates and no wrap.
REQ-015 A level already equal to its target SHALL hold.
REQ-016 If led_in changes mid-fade, the channel SHALL reverse direction on the next tick from its current level, with no jump.
REQ-017 The block SHALL register led_out[i] as enable AND ((eff[i]==255) OR (pwm_cnt < eff[i])), with 1-cycle latency from pwm_cnt/eff.
REQ-018 The definition in REQ-017 SHALL make level 0 give a constant 0 and level 255 give a constant 1.
REQ-019 The block SHALL register busy as OR over i of (level[i] != target[i]), using the current led_in.
REQ-020 While enable=0, levels SHALL freeze, led_out SHALL be 0 on the next cycle, and busy SHALL still be reported.
REQ-021 When enable rises, fading SHALL resume from the frozen levels and the prescaler value.
REQ-022 The block SHALL have no state machine beyond the counters; each channel is an independent up/down saturating counter.

Reset
REQ-023 While resetn=0, pwm_cnt, prescaler, all level[i], led_out and busy SHALL be 0, asynchronously.
REQ-024 After resetn is released, the block SHALL run normally from the first clkin edge; the first tick SHALL occur PRESCALE cycles after release with enable=1.
REQ-025 A reset asserted mid-fade SHALL discard progress, so that all LEDs are off immediately with no fade-out.

Configuration
REQ-026 The macro LED_FADE_GAMMA_EN SHALL select the PWM compare value eff[i].
REQ-027 When LED_FADE_GAMMA_EN is defined, eff[i] SHALL be (level[i]*level[i])>>8, except that level 255 SHALL map to eff=255, giving perceptually linear fades from one 8x8 multiplier per channel or a shared time-multiplexed one whose result is registered before the compare.
REQ-028 When LED_FADE_GAMMA_EN is not defined, eff[i] SHALL equal level[i] and the block SHALL contain no multiplier.
REQ-029 Fade timing and busy SHALL be identical in both builds.

Verification
REQ-030 Scenario reset: resetn=0 with led_in=12'hFFF -> led_out=0, busy=0; release -> busy=1 on the next cycle and led_out stays 0 until the first tick.
REQ-031 Scenario ramp up: PRESCALE=4, STEP=64, led_in[0]=1 from reset -> level0 reaches 64, 128, 192 and 255 at cycles 4, 8, 12 and 16; busy falls the cycle after 255; led_out[0] is then constant 1.
REQ-032 Scenario duty: level0 held at 64 (enable toggled low after the first tick, then high) -> led_out[0] high for exactly 64 of each 256 consecutive cycles (non-gamma build).
REQ-033 Scenario reversal: in the REQ-031 setup, drop led_in[0] at level 192 -> next ticks give 128, 64, 0; busy=0 after 0; with STEP=100, rising saturates 200->255 and falling 55->0 with no wrap.
REQ-034 Scenario enable/reset mid-fade: enable=0 at level 128 -> led_out=0 the next cycle and level frozen across 100 cycles; resetn pulse -> all levels 0 at once.
REQ-035 Scenario gamma build: level 128 -> eff 64 gives a duty of 64/256; level 255 gives a constant 1; level 15 -> eff 0 gives a constant 0.
